// File: rtl/regfile_mp.sv
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised multi-port register file with optional
//                hardwired-zero register, write-first bypass and collision flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp #(
    parameter int N        = 64,
    parameter int REGS     = 32,
    parameter int AW       = 5,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NWRITE-1:0]     we,
    input  logic [NWRITE*AW-1:0]  wa,
    input  logic [NWRITE*N-1:0]   wd,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*N-1:0]    rd,
    output logic                  wcollide
);

    if (((2 ** AW) < REGS) || (NREAD < 1) || (NREAD > 4) ||
        (NWRITE < 1) || (NWRITE > 2)) begin : g_param_err
        $error("regfile_mp: illegal parameter combination");
    end

    // An address is usable only if it is in range and not the zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'({1'b0, a}) < REGS) && (int'({1'b0, a}) != ZERO_REG);
    endfunction

    logic [N-1:0]  mem_q [REGS];
    logic [N-1:0]  mem_d [REGS];
    logic          wcollide_q;

    logic [AW-1:0] w_wa     [NWRITE];
    logic [N-1:0]  w_wd     [NWRITE];
    logic          w_wvalid [NWRITE];
    logic [AW-1:0] w_ra     [NREAD];
    logic [N-1:0]  w_rdata  [NREAD];
    logic          w_coll;

    for (genvar k = 0; k < NWRITE; k++) begin : g_wport
        assign w_wa[k]     = wa[k*AW +: AW];
        assign w_wd[k]     = wd[k*N +: N];
        assign w_wvalid[k] = we[k] && addr_ok(w_wa[k]);
    end

    for (genvar j = 0; j < NREAD; j++) begin : g_rport
        assign w_ra[j]        = ra[j*AW +: AW];
        assign rd[j*N +: N]   = w_rdata[j];
    end

    if (NWRITE == 2) begin : g_coll
        assign w_coll = w_wvalid[0] && w_wvalid[1] && (w_wa[0] == w_wa[1]);
    end else begin : g_nocoll
        assign w_coll = 1'b0;
    end

    // Ports are applied in ascending order so the highest index wins a collision.
    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < NWRITE; k++) begin
            for (int r = 0; r < REGS; r++) begin
                if (w_wvalid[k] && (w_wa[k] == AW'(r))) begin
                    mem_d[r] = w_wd[k];
                end
            end
        end
    end

    // Reads are forced to zero during reset so a pending write cannot bypass.
    always_comb begin
        for (int j = 0; j < NREAD; j++) begin
            w_rdata[j] = '0;
            if (reset_n && addr_ok(w_ra[j])) begin
                for (int r = 0; r < REGS; r++) begin
                    if (w_ra[j] == AW'(r)) begin
                        w_rdata[j] = mem_q[r];
                    end
                end
                if (BYPASS != 0) begin
                    for (int k = 0; k < NWRITE; k++) begin
                        if (w_wvalid[k] && (w_wa[k] == w_ra[j])) begin
                            w_rdata[j] = w_wd[k];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < REGS; r++) begin
                mem_q[r] <= '0;
            end
            wcollide_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wcollide_q <= w_coll;
        end
    end

    assign wcollide = wcollide_q;

endmodule

`default_nettype wire
